pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
Run-control and hazard controller for the 8-bit 4-stage (IF, ID, EX, WB) processor pipeline.
- Sequences instruction-memory loading through a valid/ready byte stream.
- Gates the pipeline with run / halt / single-step / drain control.
- Generates the EX-stage forwarding selects for both ALU operands.
- Sits beside the IF/ID, ID/EX and EX/WB pipeline registers and the instruction memory write port.

Parameters:
IMEM_AW, 4, instruction memory address width (2^IMEM_AW bytes).
HALT_INSTR, 8'hFF, instruction code in ID that triggers drain-then-halt.
DRAIN_CYC, 2, cycles pipeline stays enabled after halt decision so older instructions retire.

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  begin/resume execution (IDLE or HALT)
halt_req  in  1  external halt request (RUN only)
step  in  1  advance pipeline one cycle (HALT only)
ld_start  in  1  begin program load (IDLE or HALT)
ld_valid  in  1  loader byte valid
ld_data  in  8  loader byte
ld_last  in  1  qualifies final byte of program
ld_ready  out  1  controller accepts byte
imem_we  out  1  instruction memory write enable
imem_waddr  out  IMEM_AW  instruction memory write address
imem_wdata  out  8  instruction memory write data
instr_id  in  8  instruction in IF/ID register ([2:0] src1, [5:3] src2/dest)
regwrite_ex  in  1  RegWrite of ID/EX register
wreg_ex  in  3  destination of ID/EX register
regwrite_wb  in  1  RegWrite of EX/WB register
wreg_wb  in  3  destination of EX/WB register
pipe_en  out  1  enable for PC and all pipeline registers
flush  out  1  IF/ID loads NOP instead of fetched instruction
pc_rst  out  1  one-cycle PC clear
fwd_a  out  2  operand-1 select: 00 regfile, 01 EX/WB ALU result, 10 WB write-data bypass
fwd_b  out  2  operand-2 select, same encoding (ignored by datapath when ALU_src=1)
state  out  3  IDLE=0, LOAD=1, RUN=2, DRAIN=3, HALT=4, STEP=5
halted  out  1  high in HALT
ld_ovf  out  1  sticky: load wrapped address space
cycle_cnt  out  16  count of cycles with pipe_en=1

Behaviour:
- Reset values:
  - state=IDLE.
  - All outputs 0, including imem_waddr, cycle_cnt, fwd_a/b and ld_ovf.
  - Reset overrides any state, including mid-LOAD and mid-DRAIN.
- Output timing:
  - pipe_en, flush, ld_ready and halted are Moore outputs of state.
  - imem_we, imem_wdata and pc_rst are registered, one cycle after the accepting edge.
- IDLE:
  - pipe_en=0.
  - ld_start -> LOAD (ld_start wins over start in the same cycle).
  - start -> RUN.
- LOAD:
  - The ld_start edge clears the address counter and ld_ovf.
  - ld_ready=1.
  - Byte accepted when ld_valid&&ld_ready.
  - On acceptance: imem_we=1, imem_wdata=ld_data, imem_waddr=current counter, then counter++.
  - Counter wraps from 2^IMEM_AW-1 to 0 and sets ld_ovf.
  - Accepted byte with ld_last -> IDLE and pc_rst=1 for one cycle.
  - start/halt_req/step are ignored.
- RUN:
  - pipe_en=1.
  - On halt_req, or instr_id==HALT_INSTR with pipe_en=1 -> DRAIN. Both in the same cycle -> single DRAIN.
- DRAIN:
  - pipe_en=1, flush=1 for exactly DRAIN_CYC cycles (internal counter), then HALT.
  - Inputs are ignored.
- HALT:
  - pipe_en=0, halted=1.
  - Priority: ld_start -> LOAD, then start -> RUN, then step -> STEP.
- STEP:
  - One cycle with pipe_en=1, flush=0, then HALT.
  - step held high produces one step per HALT/STEP pair (every 2 cycles).
- Forwarding (registered, updated only on edges with pipe_en=1, so it is aligned with the ID/EX register):
  - fwd_a = 01 if regwrite_ex && wreg_ex==instr_id[2:0].
  - Else fwd_a = 10 if regwrite_wb && wreg_wb==instr_id[2:0].
  - Else fwd_a = 00.
  - fwd_b is the same using instr_id[5:3]. EX has priority over WB.
  - With flush=1 the loaded fwd_a/b = 00.
  - Held when pipe_en=0.
- cycle_cnt:
  - Increments on every edge with pipe_en=1, saturating at 16'hFFFF.
  - Cleared by pc_rst and by reset.

Test Plan:
1. Reset mid-LOAD after 3 bytes -> next cycle state=0, imem_waddr=0, ld_ready=0, ld_ovf=0, cycle_cnt=0.
2. ld_start, then bytes 8'h49, 8'h0A, 8'hFF with ld_last on the third, ld_valid toggling -> imem writes addr 0,1,2 with those data; pc_rst one pulse; state=IDLE.
3. Load 17 bytes with IMEM_AW=4, last on byte 17 -> 17th byte written at addr 0; ld_ovf=1.
4. start, then instr_id=8'hFF in RUN -> DRAIN with pipe_en=1, flush=1 for 2 cycles; HALT with halted=1, pipe_en=0; cycle_cnt frozen.
5. In HALT, step held high 4 cycles -> pipe_en pulses exactly twice; state alternates 4,5,4,5.
6. RUN with regwrite_ex=1, wreg_ex=3, regwrite_wb=1, wreg_wb=3, instr_id=8'b00_011_011 -> fwd_a=01, fwd_b=01. Then regwrite_ex=0 -> fwd_a=fwd_b=10.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Run-control and hazard controller for the 4-stage 8-bit pipeline: program
// loading, run/halt/step/drain sequencing and EX-stage operand forwarding.

module pipe_ctrl_fwd_sel (
  input  logic [2:0] i_src,
  input  logic       i_regwrite_ex,
  input  logic [2:0] i_wreg_ex,
  input  logic       i_regwrite_wb,
  input  logic [2:0] i_wreg_wb,
  output logic [1:0] o_sel
);
  // The instruction in EX is younger than the one in WB, so its result wins.
  always_comb begin
    o_sel = 2'b00;
    if (i_regwrite_ex && (i_wreg_ex == i_src))      o_sel = 2'b01;
    else if (i_regwrite_wb && (i_wreg_wb == i_src)) o_sel = 2'b10;
  end
endmodule

module pipe_ctrl #(
  parameter int          IMEM_AW    = 4,
  parameter logic [7:0]  HALT_INSTR = 8'hFF,
  parameter int          DRAIN_CYC  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               halt_req,
  input  logic               step,
  input  logic               ld_start,
  input  logic               ld_valid,
  input  logic [7:0]         ld_data,
  input  logic               ld_last,
  output logic               ld_ready,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_waddr,
  output logic [7:0]         imem_wdata,
  input  logic [7:0]         instr_id,
  input  logic               regwrite_ex,
  input  logic [2:0]         wreg_ex,
  input  logic               regwrite_wb,
  input  logic [2:0]         wreg_wb,
  output logic               pipe_en,
  output logic               flush,
  output logic               pc_rst,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic [2:0]         state,
  output logic               halted,
  output logic               ld_ovf,
  output logic [15:0]        cycle_cnt
);
  localparam int NUM_OPS = 2;
  localparam int DW      = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_LOAD = 3'd1, S_RUN = 3'd2,
    S_DRAIN = 3'd3, S_HALT = 3'd4, S_STEP = 3'd5
  } state_t;

  state_t                      r_state, w_next;
  logic [DW-1:0]               r_dcnt;
  logic [IMEM_AW-1:0]          r_addr, r_waddr;
  logic                        r_ovf, r_we, r_pc_rst;
  logic [7:0]                  r_wdata;
  logic [15:0]                 r_cnt;
  logic [NUM_OPS-1:0][1:0]     r_fwd, w_sel;
  logic [NUM_OPS-1:0][2:0]     w_src;
  logic                        w_accept, w_ld_begin, w_drain_begin, w_pipe_en, w_flush;

  assign w_pipe_en = (r_state == S_RUN) || (r_state == S_DRAIN) || (r_state == S_STEP);
  assign w_flush   = (r_state == S_DRAIN);
  assign w_accept  = (r_state == S_LOAD) && ld_valid;

  always_comb begin
    w_next        = r_state;
    w_ld_begin    = 1'b0;
    w_drain_begin = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ld_start)   begin w_next = S_LOAD; w_ld_begin = 1'b1; end
        else if (start) w_next = S_RUN;
      end
      S_LOAD:  if (w_accept && ld_last) w_next = S_IDLE;
      S_RUN: begin
        if (halt_req || (instr_id == HALT_INSTR)) begin
          w_next        = S_DRAIN;
          w_drain_begin = 1'b1;
        end
      end
      S_DRAIN: if (r_dcnt == '0) w_next = S_HALT;
      S_HALT: begin
        if (ld_start)   begin w_next = S_LOAD; w_ld_begin = 1'b1; end
        else if (start) w_next = S_RUN;
        else if (step)  w_next = S_STEP;
      end
      S_STEP:  w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  genvar g;
  generate
    for (g = 0; g < NUM_OPS; g++) begin : g_fwd
      assign w_src[g] = instr_id[3*g +: 3];
      pipe_ctrl_fwd_sel u_sel (
        .i_src         (w_src[g]),
        .i_regwrite_ex (regwrite_ex),
        .i_wreg_ex     (wreg_ex),
        .i_regwrite_wb (regwrite_wb),
        .i_wreg_wb     (wreg_wb),
        .o_sel         (w_sel[g])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dcnt   <= '0;
      r_addr   <= '0;
      r_waddr  <= '0;
      r_ovf    <= 1'b0;
      r_we     <= 1'b0;
      r_wdata  <= '0;
      r_pc_rst <= 1'b0;
      r_cnt    <= '0;
      r_fwd    <= '0;
    end else begin
      r_we     <= w_accept;
      r_pc_rst <= w_accept && ld_last;
      if (w_ld_begin) begin
        r_addr <= '0;
        r_ovf  <= 1'b0;
      end else if (w_accept) begin
        r_waddr <= r_addr;
        r_wdata <= ld_data;
        r_addr  <= r_addr + 1'b1;
        if (r_addr == '1) r_ovf <= 1'b1;
      end
      if (w_drain_begin)             r_dcnt <= DW'(DRAIN_CYC - 1);
      else if (w_flush && r_dcnt != '0) r_dcnt <= r_dcnt - 1'b1;
      if (r_pc_rst)                              r_cnt <= '0;
      else if (w_pipe_en && r_cnt != 16'hFFFF)   r_cnt <= r_cnt + 16'd1;
      // Loaded in step with ID/EX so selects line up with the operands in EX.
      if (w_pipe_en) r_fwd <= w_flush ? '0 : w_sel;
    end
  end

  assign state      = r_state;
  assign ld_ready   = (r_state == S_LOAD);
  assign halted     = (r_state == S_HALT);
  assign pipe_en    = w_pipe_en;
  assign flush      = w_flush;
  assign imem_we    = r_we;
  assign imem_waddr = r_waddr;
  assign imem_wdata = r_wdata;
  assign pc_rst     = r_pc_rst;
  assign ld_ovf     = r_ovf;
  assign cycle_cnt  = r_cnt;
  assign fwd_a      = r_fwd[0];
  assign fwd_b      = r_fwd[1];
endmodule
